// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the chunked adder/subtractor:
//   - opsel encodings (OP_*)
//   - FSM state type (IDLE / BUSY / DONE)
//   - carry-in source type and the per-opsel operand control decode
// Every operation is reduced to X + Y + c0, where decode_op tells the
// datapath whether to swap op1/op2, whether to invert Y, and where c0 comes from.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SBC = 3'b101;
    localparam logic [2:0] OP_RSB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        C0_ZERO = 2'd0,
        C0_ONE  = 2'd1,
        C0_CIN  = 2'd2
    } c0_src_t;

    typedef struct packed {
        logic    swap;     // X=op2, Y derived from op1 (reverse subtract)
        logic    inv_y;    // Y is the bitwise complement of its source
        c0_src_t c0_src;   // where the initial carry comes from
        logic    illegal;  // opsel is not a defined code; run as ADD
    } op_ctrl_t;

    function automatic op_ctrl_t decode_op(input logic [2:0] opsel);
        op_ctrl_t c;
        c.swap    = 1'b0;
        c.inv_y   = 1'b0;
        c.c0_src  = C0_ZERO;
        c.illegal = 1'b0;
        case (opsel)
            OP_ADD: ;
            OP_ADC: c.c0_src = C0_CIN;
            OP_SUB: begin
                c.inv_y  = 1'b1;
                c.c0_src = C0_ONE;
            end
            OP_SBC: begin
                c.inv_y  = 1'b1;
                c.c0_src = C0_CIN;
            end
            OP_RSB: begin
                c.swap   = 1'b1;
                c.inv_y  = 1'b1;
                c.c0_src = C0_ONE;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// Purely combinational CHUNK-bit adder: sum = a + b + ci.
// Ports:
//   a_i, b_i  : CHUNK-bit addends
//   ci_i      : carry into bit 0
//   sum_o     : CHUNK-bit sum
//   co_o      : carry out of bit CHUNK-1
//   cmsb_o    : carry into bit CHUNK-1 (used for signed overflow)
// -----------------------------------------------------------------------------
module addsub_slice #(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             co_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] full;

    always_comb begin
        full = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};
    end

    assign sum_o = full[CHUNK-1:0];
    assign co_o  = full[CHUNK];
    // The sum bit is a^b^carry_in, so the carry into the MSB can be
    // recovered from the MSB operands and result; valid for CHUNK=1 too.
    assign cmsb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// -----------------------------------------------------------------------------
// chunked_addsub
// Multi-cycle WIDTH-bit adder/subtractor. The operation is reduced to
// X + Y + c0 at acceptance and then evaluated LSB-first, one CHUNK-bit slice
// per clock, through a single shared addsub_slice with a registered carry.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : operation handshake; in_ready only in IDLE
//   op1, op2, opsel     : operands and operation select (see alu_pkg)
//   mode, cin           : mode=1 forces c0=cin for every opsel
//   out_valid/out_ready : result handshake; out_valid only in DONE
//   s, cout, ovf, zero  : result, carry out, signed overflow, s==0
//   illegal             : opsel was undefined (result computed as ADD)
// -----------------------------------------------------------------------------
module chunked_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       opsel,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             illegal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             carry_q,   carry_d;
    logic [WIDTH-1:0] x_q,       x_d;
    logic [WIDTH-1:0] y_q,       y_d;
    logic             pend_ill_q, pend_ill_d;
    logic [WIDTH-1:0] s_q,       s_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;
    logic             zero_q,    zero_d;
    logic             illegal_q, illegal_d;

    // Operand conditioning at acceptance
    op_ctrl_t         ctrl;
    logic [WIDTH-1:0] acc_x;
    logic [WIDTH-1:0] acc_ysrc;
    logic [WIDTH-1:0] acc_y;
    logic             acc_c0;

    always_comb begin
        ctrl     = decode_op(opsel);
        acc_x    = ctrl.swap ? op2 : op1;
        acc_ysrc = ctrl.swap ? op1 : op2;
        acc_y    = ctrl.inv_y ? ~acc_ysrc : acc_ysrc;
        if (mode) begin
            acc_c0 = cin;
        end else begin
            case (ctrl.c0_src)
                C0_ONE:  acc_c0 = 1'b1;
                C0_CIN:  acc_c0 = cin;
                default: acc_c0 = 1'b0;
            endcase
        end
    end

    // Shared slice, fed by a counter-indexed select of the latched operands
    logic [CHUNK-1:0] sl_a;
    logic [CHUNK-1:0] sl_b;
    logic [CHUNK-1:0] sl_sum;
    logic             sl_co;
    logic             sl_cmsb;

    always_comb begin
        sl_a = CHUNK'(x_q >> (int'(cnt_q) * CHUNK));
        sl_b = CHUNK'(y_q >> (int'(cnt_q) * CHUNK));
    end

    addsub_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .ci_i   (carry_q),
        .sum_o  (sl_sum),
        .co_o   (sl_co),
        .cmsb_o (sl_cmsb)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        x_d        = x_q;
        y_d        = y_q;
        pend_ill_d = pend_ill_q;
        s_d        = s_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        illegal_d  = illegal_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d        = acc_x;
                    y_d        = acc_y;
                    carry_d    = acc_c0;
                    pend_ill_d = ctrl.illegal;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        s_d[k*CHUNK +: CHUNK] = sl_sum;
                    end
                end
                carry_d = sl_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Final slice: publish the flags together with the
                    // completed result so they stay coherent in DONE/IDLE.
                    cout_d    = sl_co;
                    ovf_d     = sl_cmsb ^ sl_co;
                    zero_d    = (s_d == '0);
                    illegal_d = pend_ill_q;
                    cnt_d     = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            pend_ill_q <= 1'b0;
            s_q        <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pend_ill_q <= pend_ill_d;
            s_q        <= s_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            illegal_q  <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// -----------------------------------------------------------------------------
// tb_chunked_addsub
// Directed and randomized checks of chunked_addsub (WIDTH=128, CHUNK=32)
// against an arithmetic reference model of X + Y + c0.
// -----------------------------------------------------------------------------
module tb_chunked_addsub;

    localparam int W   = 128;
    localparam int C   = 32;
    localparam int NCH = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   opsel;
    logic         mode;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         illegal;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opsel     (opsel),
        .mode      (mode),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0b required %0b", tag, obs, exp);
        end
    endtask

    // Reference: result of X + Y + c0 as plain 129-bit arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] sel, input logic m, input logic ci,
                         output logic [W-1:0] rs, output logic rco,
                         output logic rov, output logic rz, output logic ril);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c0;
        logic [W:0]   full;
        ril = 1'b0;
        case (sel)
            3'b000: begin x = a; y = b;  c0 = 1'b0; end
            3'b001: begin x = a; y = b;  c0 = ci;   end
            3'b100: begin x = a; y = ~b; c0 = 1'b1; end
            3'b101: begin x = a; y = ~b; c0 = ci;   end
            3'b110: begin x = b; y = ~a; c0 = 1'b1; end
            default: begin x = a; y = b; c0 = 1'b0; ril = 1'b1; end
        endcase
        if (m) c0 = ci;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c0};
        rs   = full[W-1:0];
        rco  = full[W];
        // Signed overflow: same-sign addends giving a different-sign result.
        rov  = (x[W-1] == y[W-1]) && (rs[W-1] != x[W-1]);
        rz   = (rs == '0);
    endtask

    function automatic logic [W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called #1 after a rising edge while the DUT is idle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] sel, input logic m, input logic ci);
        checkb("in_ready_before_accept", in_ready, 1'b1);
        op1 = a; op2 = b; opsel = sel; mode = m; cin = ci;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operands are sampled only at acceptance; scramble them now.
        op1   = rand128();
        op2   = rand128();
        opsel = 3'($urandom_range(0, 7));
        mode  = 1'($urandom_range(0, 1));
        cin   = 1'($urandom_range(0, 1));
    endtask

    // Cycles from acceptance (cycle 0) to out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] sel, input logic m, input logic ci);
        logic [W-1:0] rs;
        logic rco, rov, rz, ril;
        model(a, b, sel, m, ci, rs, rco, rov, rz, ril);
        checkb({tag, "_out_valid"}, out_valid, 1'b1);
        checkb({tag, "_in_ready"}, in_ready, 1'b0);
        checkw({tag, "_s"}, s, rs);
        checkb({tag, "_cout"}, cout, rco);
        checkb({tag, "_ovf"}, ovf, rov);
        checkb({tag, "_zero"}, zero, rz);
        checkb({tag, "_illegal"}, illegal, ril);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkb("pop_out_valid_low", out_valid, 1'b0);
        checkb("pop_in_ready_high", in_ready, 1'b1);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] sel, input logic m, input logic ci);
        int lat;
        issue(a, b, sel, m, ci);
        wait_done(lat);
        checkw({tag, "_latency"}, W'(lat), W'(NCH + 1));
        expect_result(tag, a, b, sel, m, ci);
        pop();
    endtask

    initial begin
        int           lat;
        logic         seen_valid;
        logic [W-1:0] held_s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
        logic [2:0]   sel_tab [8];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; opsel = 3'b000; mode = 1'b0; cin = 1'b0;
        #1;
        checkb("rst_in_ready", in_ready, 1'b1);
        checkb("rst_out_valid", out_valid, 1'b0);
        checkw("rst_s", s, '0);
        checkb("rst_cout", cout, 1'b0);
        checkb("rst_ovf", ovf, 1'b0);
        checkb("rst_zero", zero, 1'b0);
        checkb("rst_illegal", illegal, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADD all-ones + 1: wraps to zero with carry out
        full_op("add_wrap", {W{1'b1}}, W'(1), 3'b000, 1'b0, 1'b0);

        // SUB 5 - 7 and the most-negative minus one overflow case
        issue(W'(5), W'(7), 3'b100, 1'b0, 1'b0);
        wait_done(lat);
        checkw("sub_neg_s_const", s, {{(W-1){1'b1}}, 1'b0});
        checkb("sub_neg_cout_const", cout, 1'b0);
        checkb("sub_neg_ovf_const", ovf, 1'b0);
        pop();
        issue(W'(1) << (W-1), W'(1), 3'b100, 1'b0, 1'b0);
        wait_done(lat);
        checkw("sub_ovf_s_const", s, (W'(1) << (W-1)) - W'(1));
        checkb("sub_ovf_ovf_const", ovf, 1'b1);
        expect_result("sub_ovf", W'(1) << (W-1), W'(1), 3'b100, 1'b0, 1'b0);
        pop();

        // ADC carry rippling through every slice boundary
        a = (W'(1) << 96) - W'(1);
        issue(a, '0, 3'b001, 1'b0, 1'b1);
        wait_done(lat);
        checkw("adc_chain_s_const", s, W'(1) << 96);
        expect_result("adc_chain", a, '0, 3'b001, 1'b0, 1'b1);
        pop();

        // mode=1 overrides SUB's forced carry with cin=0
        issue(W'(5), W'(3), 3'b100, 1'b1, 1'b0);
        wait_done(lat);
        checkw("sub_mode1_s_const", s, W'(1));
        pop();

        // Hold out_ready low in DONE; in_valid pulses must be ignored
        issue(W'(3), W'(10), 3'b110, 1'b0, 1'b0);
        wait_done(lat);
        checkw("rsb_s_const", s, W'(7));
        held_s = s;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            op1 = rand128(); op2 = rand128(); opsel = 3'b000;
            @(posedge clk); #1;
            checkb("hold_out_valid", out_valid, 1'b1);
            checkb("hold_in_ready", in_ready, 1'b0);
            checkw("hold_s", s, held_s);
        end
        in_valid = 1'b0;
        expect_result("rsb_after_hold", W'(3), W'(10), 3'b110, 1'b0, 1'b0);
        pop();

        // Illegal opsel runs as ADD and flags illegal
        issue(W'(1), W'(2), 3'b111, 1'b0, 1'b0);
        wait_done(lat);
        checkw("illegal_s_const", s, W'(3));
        checkb("illegal_flag_const", illegal, 1'b1);
        pop();

        // Asynchronous reset in cycle 2 of a BUSY operation
        issue(rand128(), rand128(), 3'b000, 1'b0, 1'b0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checkb("midrst_out_valid", out_valid, 1'b0);
        checkb("midrst_in_ready", in_ready, 1'b1);
        checkw("midrst_s", s, '0);
        checkb("midrst_illegal", illegal, 1'b0);
        checkb("midrst_cout", cout, 1'b0);
        checkb("midrst_zero", zero, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        checkb("midrst_no_out_valid", seen_valid, 1'b0);
        full_op("post_reset", W'(123456789), W'(987654321), 3'b000, 1'b0, 1'b0);

        // Randomized operations, with carry-heavy operand patterns mixed in
        sel_tab[0] = 3'b000; sel_tab[1] = 3'b001; sel_tab[2] = 3'b100; sel_tab[3] = 3'b101;
        sel_tab[4] = 3'b110; sel_tab[5] = 3'b010; sel_tab[6] = 3'b011; sel_tab[7] = 3'b111;
        for (int i = 0; i < 24; i++) begin
            a = rand128();
            case ($urandom_range(0, 3))
                0: b = ~a;
                1: b = a;
                2: begin a = {W{1'b1}}; b = rand128(); end
                default: b = rand128();
            endcase
            sel = sel_tab[$urandom_range(0, 7)];
            full_op("rand", a, b, sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Parametrised, multi-cycle wide adder/subtractor for the ALU datapath. Generalises the single-width 128-bit carry-generate adder.
- Processes a WIDTH-bit operation LSB-first, one CHUNK-bit slice per clock, with a registered carry between slices.
- Uses a valid/ready handshake on both input and output. Adds the carry-in, overflow, zero and illegal-op outputs that the combinational adder lacks.
- Sits between the ALU operand registers and the result mux.

Parameters:
- WIDTH, 128, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 32, bits processed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opsel are valid.
- in_ready  output  1  block accepts a new operation.
- op1  input  WIDTH  operand A.
- op2  input  WIDTH  operand B.
- opsel  input  3  operation select (see Behaviour).
- mode  input  1  0 = forced carry-in per opsel; 1 = carry-in taken from cin.
- cin  input  1  external carry-in, used when mode=1 or for ADC/SBC.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  s == 0.
- illegal  output  1  opsel was not a defined code.

Behaviour:
- NCHUNK = WIDTH/CHUNK.
- Reset (asynchronous, any state): FSM = IDLE. in_ready=1, out_valid=0, s=0, cout=0, ovf=0, zero=0, illegal=0. The chunk counter and the carry register are cleared. An operation in flight is discarded and produces no output.
- Operations, defined as X + Y + c0:
  - 000 ADD: X=op1, Y=op2, c0=0.
  - 001 ADC: X=op1, Y=op2, c0=cin.
  - 100 SUB: X=op1, Y=~op2, c0=1.
  - 101 SBC: X=op1, Y=~op2, c0=cin.
  - 110 RSB: X=op2, Y=~op1, c0=1.
- mode=1 overrides c0 with cin for every opsel.
- Any other opsel: executed as ADD, with illegal=1 reported alongside that result.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, latch X, Y, c0 and the illegal flag; counter <= 0; go to BUSY.
- BUSY: in_ready=0.
  - Each cycle, slice k = counter adds X[k], Y[k] and the carry register. Write the sum to s[k*CHUNK +: CHUNK] and the slice carry-out to the carry register; counter increments.
  - When counter = NCHUNK-1, that slice completes; go to DONE.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured on the last slice.
- DONE: out_valid=1, and s/cout/ovf/zero/illegal are held stable.
  - On out_ready, go to IDLE with out_valid=0 on the next cycle.
  - Results stay readable until the next accept.
  - No back-to-back acceptance: in_ready is 1 only in IDLE.
- Latency: handshake accepted in cycle 0 → out_valid high in cycle NCHUNK+1. Throughput is one operation per NCHUNK+2 cycles with out_ready held high.
- Operands are sampled only at acceptance; later changes on op1/op2/opsel/cin are ignored.
- NCHUNK=1 degenerates to one BUSY cycle.
- zero is computed over the full registered s once DONE is entered.
- Result outputs in IDLE hold the last completed result. They are meaningful only while out_valid=1.

Decomposition:
- Package alu_pkg holds:
  - opsel localparams OP_ADD=3'b000, OP_ADC=3'b001, OP_SUB=3'b100, OP_SBC=3'b101, OP_RSB=3'b110;
  - state enum typedef {IDLE, BUSY, DONE};
  - a function returning (Y-invert, c0 source) per opsel.
- One sub-module, addsub_slice, parametrised by CHUNK:
  - combinational a+b+ci;
  - outputs sum, co, and the carry into the MSB (for overflow).
- Instantiate addsub_slice once, reused each cycle via a counter-indexed mux. Do not instantiate it NCHUNK times.

Test Plan (WIDTH=128, CHUNK=32):
- ADD, mode=0: op1=2^128-1, op2=1 → s=0, cout=1, zero=1, ovf=0. out_valid exactly 5 cycles after accept.
- SUB, mode=0: op1=5, op2=7 → s=2^128-2, cout=0, ovf=0. Then op1=2^127, op2=1 → s=2^127-1, ovf=1.
- ADC/mode=1 carry chaining, cin=1:
  - ADC with op1=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, op2=0 → s=0x1_0000_0000_0000_0000_0000_0000. This checks carry across every slice boundary.
  - SUB with mode=1, cin=0: op1=5, op2=3 → s=1.
- Handshake: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, and in_valid pulses are ignored. Release → IDLE, and the next op is accepted.
- Reset mid-BUSY, asserted in cycle 2 → all outputs return to reset values asynchronously, no out_valid appears, and the next op gives a correct result.
- RSB op1=3, op2=10 → s=7. Illegal opsel 3'b111 with op1=1, op2=2 → s=3, illegal=1.
